// File: rtl/skyhop_pkg.sv
// Shared definitions for the skyhop screen flow: screen state codes and the
// counter-width helper used by the sequencer, overlay and score blocks.
package skyhop_pkg;

  typedef enum logic [1:0] {
    SCR_START = 2'd0,
    SCR_PLAY  = 2'd1,
    SCR_OVER  = 2'd2,
    SCR_BAD   = 2'd3
  } scr_state_t;

  // A counter for n frames needs $clog2(n) bits, but never fewer than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Signals between the screen sequencer and the timing chain, game logic and
// overlay stages.
interface screen_sequencer_if;

  logic vblnk_in;
  logic btn_start;
  logic player_dead;
  logic start_en;
  logic game_en;
  logic over_en;
  logic game_rst;
  logic blink;
  logic frame_tick;

  modport master (
    output vblnk_in, btn_start, player_dead,
    input  start_en, game_en, over_en, game_rst, blink, frame_tick
  );

  modport slave (
    input  vblnk_in, btn_start, player_dead,
    output start_en, game_en, over_en, game_rst, blink, frame_tick
  );

endinterface

// File: rtl/rise_detect.sv
// Registered 0->1 edge detector. The delay register resets to RESET_VAL so a
// level already high when reset releases does not look like a fresh edge.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q   <= RESET_VAL;
      pulse <= 1'b0;
    end else begin
      d_q   <= d;
      pulse <= d & ~d_q;
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Start / play / game-over screen sequencer. All screen changes are taken on
// the frame tick, so overlay enables never switch in the middle of a frame.
module screen_sequencer
  import skyhop_pkg::*;
#(
  parameter int OVER_HOLD_FRAMES = 120,
  parameter int BLINK_FRAMES     = 30
) (
  input logic               clk,
  input logic               rst,
  screen_sequencer_if.slave bus
);

  localparam int HW = cnt_width(OVER_HOLD_FRAMES);
  localparam int BW = cnt_width(BLINK_FRAMES);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(OVER_HOLD_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic          tick;
  logic          btn_rise;
  logic          start_req_q, dead_req_q;
  logic          start_hit, dead_hit;
  scr_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          game_rst_c;
  logic          start_en_q, game_en_q, over_en_q;
  logic          blink_q;
  logic [BW-1:0] blink_cnt_q;

  rise_detect #(.RESET_VAL(1'b1)) u_vblnk_rise (
    .clk   (clk),
    .rst   (rst),
    .d     (bus.vblnk_in),
    .pulse (tick)
  );

  rise_detect #(.RESET_VAL(1'b1)) u_btn_rise (
    .clk   (clk),
    .rst   (rst),
    .d     (bus.btn_start),
    .pulse (btn_rise)
  );

  // Every tick consumes the requests, used or not, so stale presses never
  // carry into the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_req_q <= 1'b0;
      dead_req_q  <= 1'b0;
    end else if (tick) begin
      start_req_q <= 1'b0;
      dead_req_q  <= 1'b0;
    end else begin
      if (btn_rise)        start_req_q <= 1'b1;
      if (bus.player_dead) dead_req_q  <= 1'b1;
    end
  end

  // Requests landing in the tick cycle itself still count at that tick.
  assign start_hit = start_req_q | btn_rise;
  assign dead_hit  = dead_req_q | bus.player_dead;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCR_START;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    game_rst_c = 1'b0;
    case (state_q)
      SCR_START: begin
        if (tick && start_hit) begin
          state_d    = SCR_PLAY;
          game_rst_c = 1'b1;
        end
      end
      SCR_PLAY: begin
        if (tick && dead_hit) begin
          state_d = SCR_OVER;
          hold_d  = HOLD_LOAD;
        end
      end
      SCR_OVER: begin
        if (tick) begin
          if (hold_q != '0)   hold_d  = hold_q - 1'b1;
          else if (start_hit) state_d = SCR_START;
        end
      end
      default: begin
        state_d = SCR_START;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_en_q <= 1'b1;
      game_en_q  <= 1'b0;
      over_en_q  <= 1'b0;
    end else begin
      start_en_q <= (state_q == SCR_START);
      game_en_q  <= (state_q == SCR_PLAY);
      over_en_q  <= (state_q == SCR_OVER);
    end
  end

  // Prompt blink restarts visible whenever START is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else if (state_q != SCR_START) begin
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else if (tick) begin
      if (state_d != SCR_START) begin
        blink_q     <= 1'b1;
        blink_cnt_q <= '0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_q     <= ~blink_q;
        blink_cnt_q <= '0;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign bus.frame_tick = tick;
  assign bus.game_rst   = game_rst_c;
  assign bus.start_en   = start_en_q;
  assign bus.game_en    = game_en_q;
  assign bus.over_en    = over_en_q;
  assign bus.blink      = blink_q;

endmodule
